running_min_tracker: RTL

//  Downstream stage of the SVP compare tree. Consumes one reduced (value, user-index) beat per tree output.

---
 rtl/svp_pkg.sv | 28 ++
 rtl/running_min_tracker_if.sv | 38 +++
 rtl/svp_res_slot.sv | 68 ++++++
 rtl/running_min_tracker.sv | 131 +++++++++++++
 4 files changed

// File: rtl/svp_pkg.sv
// ============================================================================
//  svp_pkg : shared types and the signed select rule of the SVP compare path
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package svp_pkg;

   localparam int SVP_DATA_W  = 16;
   localparam int SVP_USER_W  = 7;
   localparam int SVP_BATCH_W = 3;

   typedef struct packed {
      logic signed [SVP_DATA_W-1:0] val;
      logic        [SVP_USER_W-1:0] user;
      logic        [SVP_BATCH_W-1:0] batch;
   } svp_res_t;

   // Callers sign-extend to 64 bits so any tree width shares one compare.
   function automatic logic svp_better(input logic signed [63:0] a,
                                       input logic signed [63:0] b,
                                       input logic               is_min);
      return is_min ? (a < b) : (a > b);
   endfunction

endpackage

`default_nettype wire

// File: rtl/running_min_tracker_if.sv
// ============================================================================
//  running_min_tracker_if : beat input and result handshake bundle
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface running_min_tracker_if #(
   parameter int DATA_WIDTH = 16,
   parameter int USER_WIDTH = 7,
   parameter int BATCH_NUM  = 8
);
   localparam int BATCH_W = (BATCH_NUM > 1) ? $clog2(BATCH_NUM) : 1;

   logic signed [DATA_WIDTH-1:0] val_i;
   logic        [USER_WIDTH-1:0] user_i;
   logic                         vld_i;
   logic                         clr_i;
   logic signed [DATA_WIDTH-1:0] res_val_o;
   logic        [USER_WIDTH-1:0] res_user_o;
   logic        [BATCH_W-1:0]    res_batch_o;
   logic                         res_vld_o;
   logic                         res_rdy_i;
   logic                         ovf_o;
   logic                         busy_o;

   modport master (
      output val_i, user_i, vld_i, clr_i, res_rdy_i,
      input  res_val_o, res_user_o, res_batch_o, res_vld_o, ovf_o, busy_o
   );

   modport slave (
      input  val_i, user_i, vld_i, clr_i, res_rdy_i,
      output res_val_o, res_user_o, res_batch_o, res_vld_o, ovf_o, busy_o
   );

endinterface

`default_nettype wire

// File: rtl/svp_res_slot.sv
// ============================================================================
//  svp_res_slot : single-entry valid/ready result register with drop pulse
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module svp_res_slot #(
   parameter int W = 8
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   input  wire logic         load_i,
   input  wire logic [W-1:0] data_i,
   input  wire logic         rdy_i,
   output logic      [W-1:0] data_o,
   output logic              vld_o,
   output logic              ovf_o
);

   typedef enum logic [0:0] {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_state_t;

   slot_state_t  state_q, state_d;
   logic [W-1:0] data_q, data_d;
   logic         ovf_q, ovf_d;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      ovf_d   = 1'b0;
      unique case (state_q)
         SLOT_EMPTY: begin
            if (load_i) begin
               data_d  = data_i;
               state_d = SLOT_FULL;
            end
         end
         SLOT_FULL: begin
            if (rdy_i) begin
               if (load_i) data_d = data_i;
               else        state_d = SLOT_EMPTY;
            end else if (load_i) begin
               // Port stalled: keep the older result, report the newer one as lost.
               ovf_d = 1'b1;
            end
         end
         default: state_d = SLOT_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= SLOT_EMPTY;
         data_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         ovf_q   <= ovf_d;
      end
   end

   assign data_o = data_q;
   assign vld_o  = (state_q == SLOT_FULL);
   assign ovf_o  = ovf_q;

endmodule

`default_nettype wire

// File: rtl/running_min_tracker.sv
// ============================================================================
//  running_min_tracker : per-frame min/max of tree beats with valid/ready result
//  Option macro RUNNING_MIN_TRACKER_OVF_CNT_EN adds a saturating drop counter.
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module running_min_tracker
   import svp_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int USER_WIDTH = 7,
   parameter int BATCH_NUM  = 8,
   parameter     TYPE       = "min"
) (
   input  wire logic              clk,
   input  wire logic              rst_n,
   running_min_tracker_if.slave   bus
`ifdef RUNNING_MIN_TRACKER_OVF_CNT_EN
   ,
   output logic [15:0]            ovf_cnt_o
`endif
);

   localparam int BATCH_W = (BATCH_NUM > 1) ? $clog2(BATCH_NUM) : 1;
   localparam int RES_W   = DATA_WIDTH + USER_WIDTH + BATCH_W;
   localparam bit IS_MIN  = (TYPE == "min");
   localparam logic [BATCH_W-1:0] LAST_BEAT = BATCH_W'(BATCH_NUM - 1);

   typedef struct packed {
      logic signed [DATA_WIDTH-1:0] val;
      logic        [USER_WIDTH-1:0] user;
      logic        [BATCH_W-1:0]    batch;
   } res_t;

   typedef enum logic [0:0] {ACC_IDLE = 1'b0, ACC_RUN = 1'b1} acc_state_t;

   acc_state_t         state_q, state_d;
   logic [BATCH_W-1:0] beat_cnt_q, beat_cnt_d;
   res_t               acc_q, acc_d;
   res_t               merged;
   res_t               res_out;
   logic               frame_done;
   logic               take_beat;
   logic               slot_ovf;

   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      acc_d      = acc_q;
      frame_done = 1'b0;

      // Beat 0 always loads; later beats must be strictly better so ties keep the earlier one.
      take_beat = (beat_cnt_q == '0) ||
                  svp_better(64'($signed(bus.val_i)), 64'($signed(acc_q.val)), IS_MIN);
      if (take_beat) begin
         merged.val   = bus.val_i;
         merged.user  = bus.user_i;
         merged.batch = beat_cnt_q;
      end else begin
         merged = acc_q;
      end

      if (bus.clr_i) begin
         beat_cnt_d = '0;
         state_d    = ACC_IDLE;
      end else if (bus.vld_i) begin
         acc_d = merged;
         if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = '0;
            state_d    = ACC_IDLE;
            frame_done = 1'b1;
         end else begin
            beat_cnt_d = beat_cnt_q + BATCH_W'(1);
            state_d    = ACC_RUN;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ACC_IDLE;
         beat_cnt_q <= '0;
         acc_q      <= '0;
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
         acc_q      <= acc_d;
      end
   end

   svp_res_slot #(
      .W (RES_W)
   ) u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (frame_done),
      .data_i (merged),
      .rdy_i  (bus.res_rdy_i),
      .data_o (res_out),
      .vld_o  (bus.res_vld_o),
      .ovf_o  (slot_ovf)
   );

   assign bus.res_val_o   = res_out.val;
   assign bus.res_user_o  = res_out.user;
   assign bus.res_batch_o = res_out.batch;
   assign bus.ovf_o       = slot_ovf;
   assign bus.busy_o      = (state_q == ACC_RUN);

`ifdef RUNNING_MIN_TRACKER_OVF_CNT_EN
   logic [15:0] ovf_cnt_q, ovf_cnt_d;

   always_comb begin
      ovf_cnt_d = ovf_cnt_q;
      if (slot_ovf && (ovf_cnt_q != 16'hFFFF)) ovf_cnt_d = ovf_cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) ovf_cnt_q <= '0;
      else        ovf_cnt_q <= ovf_cnt_d;
   end

   assign ovf_cnt_o = ovf_cnt_q;
`else
   // Without the counter, drops are visible only through the ovf_o pulse.
`endif

endmodule

`default_nettype wire
